// File: rtl/kernel_nios2_qsys_0_oci_mem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the CPU debug slave.
// Define OCI_ARB_JTAG_PRIORITY_EN for fixed JTAG-over-CPU priority; round-robin otherwise.
module kernel_nios2_qsys_0_oci_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OP_RD_A = 2'd0, OP_WR_B = 2'd1, OP_RD_NA = 2'd2} jop_t;

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  jop_t              pend_op_q, pend_op_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sel_jtag_q, sel_jtag_d;
  jop_t              sel_op_q, sel_op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] mondreg_q, mondreg_d;
  logic              ready_q, ready_d, error_q, error_d;
`ifndef OCI_ARB_JTAG_PRIORITY_EN
  logic              rr_last_q, rr_last_d;  // 1: JTAG was served last
`endif

  logic              new_is_op_s, lower_drop_s, free_s, accept_s, overrun_s;
  logic              j_valid_s, grant_j_s, grant_c_s;
  jop_t              new_op_s, j_op_s;
  logic [DATA_W-1:0] j_data_s;
  logic              unused_jdo_s;

  assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

  assign new_is_op_s  = take_action_ocimem_a ? jdo[34]
                      : (take_action_ocimem_b | take_no_action_ocimem_a);
  assign new_op_s     = take_action_ocimem_a ? OP_RD_A
                      : (take_action_ocimem_b ? OP_WR_B : OP_RD_NA);
  assign lower_drop_s = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                      | (take_action_ocimem_b & take_no_action_ocimem_a);
  // The slot frees when its JTAG op completes: writes in ISSUE, reads in RESP.
  assign free_s       = sel_jtag_q & (((state_q == S_ISSUE) & (sel_op_q == OP_WR_B))
                                     | (state_q == S_RESP));
  assign accept_s     = new_is_op_s & (~pend_valid_q | free_s);
  assign overrun_s    = new_is_op_s & pend_valid_q & ~free_s;
  assign j_valid_s    = pend_valid_q | accept_s;
  assign j_op_s       = pend_valid_q ? pend_op_q : new_op_s;
  assign j_data_s     = pend_valid_q ? pend_data_q : jdo[34:3];

`ifdef OCI_ARB_JTAG_PRIORITY_EN
  assign grant_j_s = j_valid_s;
`else
  assign grant_j_s = j_valid_s & (~cpu_req | ~rr_last_q);
`endif
  assign grant_c_s = cpu_req & ~grant_j_s;

  // JTAG slot, auto-increment address and status bits.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_data_d  = pend_data_q;
    addr_d       = addr_q;
    ready_d      = ready_q;
    error_d      = error_q;
    if (free_s) begin
      pend_valid_d = 1'b0;
      ready_d      = 1'b1;
      if (sel_op_q != OP_RD_A) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        addr_d = addr_q;
      end
    end else begin
      pend_valid_d = pend_valid_q;
    end
    if (accept_s) begin
      pend_valid_d = 1'b1;
      pend_op_d    = new_op_s;
      pend_data_d  = jdo[34:3];
      ready_d      = 1'b0;
    end else begin
      pend_op_d = pend_op_d;
    end
    if (take_action_ocimem_a) begin
      addr_d = jdo[17 +: ADDR_W];
      if (jdo[35]) begin
        error_d = 1'b0;
      end else begin
        error_d = error_q;
      end
    end else begin
      addr_d = addr_d;
    end
    if (overrun_s | lower_drop_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_d;
    end
  end

  // Access sequencer: arbitration in IDLE, one RAM strobe in ISSUE, read capture in RESP.
  always_comb begin
    state_d     = state_q;
    sel_jtag_d  = sel_jtag_q;
    sel_op_d    = sel_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    cpu_gnt_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mondreg_d   = mondreg_q;
`ifndef OCI_ARB_JTAG_PRIORITY_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_j_s) begin
          state_d     = S_ISSUE;
          sel_jtag_d  = 1'b1;
          sel_op_d    = j_op_s;
          mem_addr_d  = addr_d;
          mem_we_d    = (j_op_s == OP_WR_B);
          mem_re_d    = (j_op_s != OP_WR_B);
          mem_wdata_d = (j_op_s == OP_WR_B) ? j_data_s : {DATA_W{1'b0}};
`ifndef OCI_ARB_JTAG_PRIORITY_EN
          rr_last_d   = 1'b1;
`endif
        end else if (grant_c_s) begin
          state_d     = S_ISSUE;
          sel_jtag_d  = 1'b0;
          mem_addr_d  = cpu_addr;
          mem_we_d    = cpu_we;
          mem_re_d    = ~cpu_we;
          mem_wdata_d = cpu_we ? cpu_wdata : {DATA_W{1'b0}};
          cpu_gnt_d   = cpu_we;
`ifndef OCI_ARB_JTAG_PRIORITY_EN
          rr_last_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_re_q) begin
          state_d   = S_RESP;
          cpu_gnt_d = ~sel_jtag_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (sel_jtag_q) begin
          mondreg_d = mem_rdata;
        end else begin
          cpu_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_op_q    <= OP_RD_A;
      pend_data_q  <= {DATA_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      sel_jtag_q   <= 1'b0;
      sel_op_q     <= OP_RD_A;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      cpu_rdata_q  <= {DATA_W{1'b0}};
      mondreg_q    <= {DATA_W{1'b0}};
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
`ifndef OCI_ARB_JTAG_PRIORITY_EN
      rr_last_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_data_q  <= pend_data_d;
      addr_q       <= addr_d;
      sel_jtag_q   <= sel_jtag_d;
      sel_op_q     <= sel_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      cpu_gnt_q    <= cpu_gnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mondreg_q    <= mondreg_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
`ifndef OCI_ARB_JTAG_PRIORITY_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  // CPU read data is forwarded from the RAM during RESP so it lines up with cpu_gnt.
  assign cpu_rdata     = ((state_q == S_RESP) && !sel_jtag_q) ? mem_rdata : cpu_rdata_q;
  assign cpu_gnt       = cpu_gnt_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign MonDReg       = mondreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_kernel_nios2_qsys_0_oci_mem_arbiter.sv
// Directed bench for the OCI memory arbiter: JTAG command table plus timing, reset,
// overrun and round-robin sequences against a behavioural RAM.
module tb_kernel_nios2_qsys_0_oci_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;

  int n_tests = 0;
  int n_fail  = 0;

  kernel_nios2_qsys_0_oci_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna_a),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h01:   return 32'hA5A5_A5A5;
      8'h10:   return 32'hDEAD_BEEF;
      8'h11:   return 32'h1111_1111;
      8'h12:   return 32'h1212_1212;
      8'h20:   return 32'h2020_2020;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // RAM model: synchronous write, read data valid the cycle after mem_re.
  logic [31:0] ram [0:255];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i[7:0]);
      ram_init <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // Strobe / grant log.
  int n_we = 0, n_re = 0, n_gnt = 0, n_both = 0, gl_n = 0;
  logic [7:0] glog [0:63];
  always @(negedge clk) begin
    if (mem_we) n_we <= n_we + 1;
    if (mem_re) n_re <= n_re + 1;
    if (cpu_gnt) n_gnt <= n_gnt + 1;
    if (mem_we && mem_re) n_both <= n_both + 1;
    if ((mem_we || mem_re) && gl_n < 64) begin
      glog[gl_n[5:0]] <= mem_we ? 8'h57 : 8'h52;
      gl_n <= gl_n + 1;
    end
  end

  typedef struct {
    int          kind;     // 0 ocimem_a, 1 ocimem_b, 2 no_action_a
    logic [37:0] jdo;
    logic        chk_mon;
    logic [31:0] exp_mon;
    logic        chk_ram;
    logic [7:0]  ram_a;
    logic [31:0] ram_v;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [37:0] jdo_a(input logic [7:0] ad, input logic rd, input logic clr);
    logic [37:0] j;
    j = 38'h0;
    j[24:17] = ad;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = 38'h0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (monitor_ready && !busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({nm, " idle"}, {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_gnt(input string nm, output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_gnt) break;
    end
    check({nm, " gnt seen"}, {31'h0, cpu_gnt}, 32'h1);
  endtask

  task automatic pulse(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    case (kind)
      0:       ta_a = 1'b1;
      1:       ta_b = 1'b1;
      default: tna_a = 1'b1;
    endcase
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
  endtask

  int s_we, s_re, s_gnt, s_gl, cyc;

  initial begin
    reset_n = 1'b0; jdo = 38'h0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 32'h0;

    vecs[0] = '{0, jdo_a(8'h10, 1'b1, 1'b0), 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0};
    vecs[1] = '{2, 38'h0,                    1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0};
    vecs[2] = '{2, 38'h0,                    1'b1, 32'h1111_1111, 1'b0, 8'h00, 32'h0};
    vecs[3] = '{0, jdo_a(8'hFF, 1'b0, 1'b0), 1'b0, 32'h0,         1'b0, 8'h00, 32'h0};
    vecs[4] = '{1, jdo_b(32'h1),             1'b0, 32'h0,         1'b1, 8'hFF, 32'h1};
    vecs[5] = '{1, jdo_b(32'h2),             1'b0, 32'h0,         1'b1, 8'h00, 32'h2};
    vecs[6] = '{2, 38'h0,                    1'b1, 32'hA5A5_A5A5, 1'b0, 8'h00, 32'h0};
    vecs[7] = '{0, jdo_a(8'h00, 1'b1, 1'b0), 1'b1, 32'h0000_0002, 1'b0, 8'h00, 32'h0};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst ready", {31'h0, monitor_ready}, 32'h1);
    check("rst outs", {26'h0, monitor_error, busy, mem_we, mem_re, cpu_gnt, 1'b0}, 32'h0);
    check("rst mondreg", MonDReg, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // JTAG command table (includes address wrap 0xFF -> 0x00 -> 0x01).
    for (int v = 0; v < 8; v++) begin
      pulse(vecs[v].kind, vecs[v].jdo);
      wait_idle($sformatf("vec%0d", v));
      if (vecs[v].chk_mon) check($sformatf("vec%0d MonDReg", v), MonDReg, vecs[v].exp_mon);
      if (vecs[v].chk_ram) check($sformatf("vec%0d ram", v), ram[vecs[v].ram_a], vecs[v].ram_v);
      check($sformatf("vec%0d error", v), {31'h0, monitor_error}, 32'h0);
    end

    // Read timing: mem_re one cycle after the strobe, MonDReg two cycles after that.
    @(negedge clk);
    jdo = jdo_a(8'h10, 1'b1, 1'b0); ta_a = 1'b1;
    @(negedge clk);
    ta_a = 1'b0;
    check("t2 mem_re", {31'h0, mem_re}, 32'h1);
    check("t2 mem_we", {31'h0, mem_we}, 32'h0);
    check("t2 mem_addr", {24'h0, mem_addr}, 32'h10);
    check("t2 ready low", {31'h0, monitor_ready}, 32'h0);
    @(negedge clk);
    check("t2 MonDReg early", MonDReg, 32'h0000_0002);
    @(negedge clk);
    check("t2 MonDReg", MonDReg, 32'hDEAD_BEEF);
    check("t2 ready", {31'h0, monitor_ready}, 32'h1);

    // Overrun: second no_action read lands while the slot is busy and is dropped.
    @(negedge clk); #1;
    s_we = n_we; s_re = n_re;
    tna_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tna_a = 1'b0;
    check("t5 error set", {31'h0, monitor_error}, 32'h1);
    wait_idle("t5");
    @(negedge clk); #1;
    check("t5 one read", n_re - s_re, 32'd1);
    check("t5 no write", n_we - s_we, 32'd0);
    pulse(2, 38'h0);
    wait_idle("t5 follow");
    check("t5 addr once", MonDReg, 32'h1111_1111);
    pulse(0, jdo_a(8'h00, 1'b0, 1'b1));
    check("t5 error clear", {31'h0, monitor_error}, 32'h0);

    // Simultaneous strobes: ocimem_a wins, ocimem_b is dropped.
    @(negedge clk); #1;
    s_we = n_we;
    @(negedge clk);
    jdo = jdo_a(8'h40, 1'b0, 1'b0); ta_a = 1'b1; ta_b = 1'b1;
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0;
    check("multi error", {31'h0, monitor_error}, 32'h1);
    wait_idle("multi");
    @(negedge clk); #1;
    check("multi no write", n_we - s_we, 32'd0);
    pulse(0, jdo_a(8'h00, 1'b0, 1'b1));
    check("multi clear", {31'h0, monitor_error}, 32'h0);

    // CPU write then read-back with latency checks.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'hCAFE_F00D;
    wait_gnt("cpu wr", cyc);
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("cpu wr latency", cyc, 32'd1);
    @(negedge clk);
    check("cpu gnt pulse", {31'h0, cpu_gnt}, 32'h0);
    check("cpu wr ram", ram[8'h30], 32'hCAFE_F00D);
    cpu_req = 1'b1; cpu_addr = 8'h30;
    wait_gnt("cpu rd", cyc);
    check("cpu rd data", cpu_rdata, 32'hCAFE_F00D);
    cpu_req = 1'b0;
    check("cpu rd latency", cyc, 32'd2);
    wait_idle("cpu");

    // Reset during RESP of a JTAG read.
    @(negedge clk);
    jdo = jdo_a(8'h11, 1'b1, 1'b0); ta_a = 1'b1;
    @(negedge clk);
    ta_a = 1'b0;
    @(negedge clk);
    check("t1 busy before", {31'h0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("t1 strobes", {30'h0, mem_we, mem_re}, 32'h0);
    check("t1 ready", {31'h0, monitor_ready}, 32'h1);
    check("t1 busy", {31'h0, busy}, 32'h0);
    check("t1 MonDReg", MonDReg, 32'h0);
    check("t1 mem_addr", {24'h0, mem_addr}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    s_we = n_we; s_re = n_re;
    repeat (4) @(negedge clk);
    #1;
    check("t1 quiet", (n_we - s_we) + (n_re - s_re), 32'd0);
    check("t1 MonDReg after", MonDReg, 32'h0);

    // Round-robin: CPU read and JTAG write requested together, twice.
    s_gnt = n_gnt; s_gl = gl_n;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
      jdo = jdo_b(r == 0 ? 32'h11 : 32'h22); ta_b = 1'b1;
      @(negedge clk);
      ta_b = 1'b0;
      wait_gnt($sformatf("rr%0d", r), cyc);
      check($sformatf("rr%0d rdata", r), cpu_rdata, 32'h2020_2020);
      cpu_req = 1'b0;
      wait_idle($sformatf("rr%0d", r));
    end
    @(negedge clk); #1;
    check("rr grants", gl_n - s_gl, 32'd4);
    check("rr order", {glog[s_gl[5:0]], glog[s_gl[5:0] + 6'd1], glog[s_gl[5:0] + 6'd2],
                       glog[s_gl[5:0] + 6'd3]}, 32'h5752_5752);
    check("rr gnt count", n_gnt - s_gnt, 32'd2);
    check("rr ram0", ram[8'h00], 32'h11);
    check("rr ram1", ram[8'h01], 32'h22);
    check("never both strobes", n_both, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
